// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped fill cache: default geometry,
// tag-width derivation and the controller state encoding.
`timescale 1ns/1ps
package cache_pkg;

  localparam int WORD_DEF     = 32;
  localparam int ADDR_W_DEF   = 15;
  localparam int INDEX_W_DEF  = 10;
  localparam int OFFSET_W_DEF = 2;
  localparam int CNT_W_DEF    = 15;

  // Tag bits are whatever is left of the word address once index and offset are removed.
  function automatic int tagWidth(input int addrW, input int indexW, input int offsetW);
    return addrW - indexW - offsetW;
  endfunction

  localparam int TAG_W_DEF = tagWidth(ADDR_W_DEF, INDEX_W_DEF, OFFSET_W_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    RESP   = 2'd3
  } cacheState_t;

endpackage

// File: rtl/cache_data_ram.sv
// Cache data store: one write port, one asynchronous read port.
// Read is combinational so a hit can be answered in the lookup cycle.
`timescale 1ns/1ps
module cache_data_ram #(
  parameter int WORD = 32,
  parameter int AW   = 12
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [WORD-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [WORD-1:0] rdata
);

  logic [WORD-1:0] mem [0:(1<<AW)-1];

  // Fill words are written one per strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_cache_fill.sv
// Direct-mapped read-only cache with block refill from a word-serial memory.
// Optional hit/miss statistics are built when DM_CACHE_STATS_EN is defined;
// otherwise hit_cnt/miss_cnt are tied to zero.
`timescale 1ns/1ps
module dm_cache_fill
  import cache_pkg::*;
#(
  parameter int WORD     = WORD_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [WORD-1:0]   cpu_rdata,
  output logic              cpu_ready,
  output logic              busy,
  input  logic              inv,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [WORD-1:0]   mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W  = tagWidth(ADDR_W, INDEX_W, OFFSET_W);
  localparam int LINES  = 1 << INDEX_W;
  localparam int RAM_AW = INDEX_W + OFFSET_W;

  cacheState_t          stateReg;
  logic [ADDR_W-1:0]    reqAddrReg;
  logic                 memReqReg;
  logic [ADDR_W-1:0]    memAddrReg;
  logic [OFFSET_W-1:0]  wordCntReg;
  logic [LINES-1:0]     validReg;
  logic [TAG_W-1:0]     tagMem [0:LINES-1];

  logic [TAG_W-1:0]     reqTag;
  logic [INDEX_W-1:0]   reqIndex;
  logic [OFFSET_W-1:0]  reqOffset;
  logic                 lookupHit;
  logic                 isHit;
  logic                 fillWe;
  logic                 lastWord;
  logic [WORD-1:0]      ramRdata;

  assign reqTag    = reqAddrReg[ADDR_W-1 -: TAG_W];
  assign reqIndex  = reqAddrReg[OFFSET_W +: INDEX_W];
  assign reqOffset = reqAddrReg[OFFSET_W-1:0];

  assign lookupHit = validReg[reqIndex] && (tagMem[reqIndex] == reqTag);
  assign isHit     = (stateReg == LOOKUP) && lookupHit;
  assign fillWe    = (stateReg == FILL) && mem_rvalid;
  assign lastWord  = fillWe && (wordCntReg == {OFFSET_W{1'b1}});

  cache_data_ram #(
    .WORD (WORD),
    .AW   (RAM_AW)
  ) dataRam (
    .clk   (clk),
    .we    (fillWe),
    .waddr ({reqIndex, wordCntReg}),
    .wdata (mem_rdata),
    .raddr ({reqIndex, reqOffset}),
    .rdata (ramRdata)
  );

  // Hits answer in the lookup cycle, so the response strobe is decoded from state.
  assign cpu_ready = isHit || (stateReg == RESP);
  assign cpu_rdata = cpu_ready ? ramRdata : '0;
  assign busy      = (stateReg != IDLE);
  assign mem_req   = memReqReg;
  assign mem_addr  = memAddrReg;

  // Controller: request capture, lookup, word-serial refill and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      reqAddrReg <= '0;
      memReqReg  <= 1'b0;
      memAddrReg <= '0;
      wordCntReg <= '0;
      validReg   <= '0;
    end else begin
      memReqReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (inv) begin
            validReg <= '0;
          end else if (cpu_req) begin
            reqAddrReg <= cpu_addr;
            stateReg   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookupHit) begin
            stateReg <= IDLE;
          end else begin
            stateReg   <= FILL;
            memReqReg  <= 1'b1;
            memAddrReg <= {reqTag, reqIndex, {OFFSET_W{1'b0}}};
            wordCntReg <= '0;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            wordCntReg <= wordCntReg + 1'b1;
            if (wordCntReg == {OFFSET_W{1'b1}}) begin
              validReg[reqIndex] <= 1'b1;
              stateReg           <= RESP;
            end
          end
        end
        RESP: begin
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  // Tag array is not reset; a line only becomes usable once its valid bit is set.
  always_ff @(posedge clk) begin
    if (lastWord) begin
      tagMem[reqIndex] <= reqTag;
    end
  end

`ifdef DM_CACHE_STATS_EN
  logic             isMiss;
  logic [CNT_W-1:0] hitCntReg;
  logic [CNT_W-1:0] missCntReg;

  assign isMiss = (stateReg == LOOKUP) && !lookupHit;

  // Saturating hit/miss counters, updated once per lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hitCntReg  <= '0;
      missCntReg <= '0;
    end else begin
      if (isHit && (hitCntReg != {CNT_W{1'b1}})) begin
        hitCntReg <= hitCntReg + 1'b1;
      end
      if (isMiss && (missCntReg != {CNT_W{1'b1}})) begin
        missCntReg <= missCntReg + 1'b1;
      end
    end
  end

  assign hit_cnt  = hitCntReg;
  assign miss_cnt = missCntReg;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_cache_fill.sv
// Self-checking bench for dm_cache_fill: directed vector table, reset and
// saturation sequences, then randomized reads against a transparent-cache model.
`timescale 1ns/1ps
module tb_dm_cache_fill;

  localparam int WORD     = 32;
  localparam int ADDR_W   = 15;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 2;
  localparam int CNT_W    = 3;
`ifdef DM_CACHE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [WORD-1:0]   cpu_rdata;
  logic              cpu_ready;
  logic              busy;
  logic              inv = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid = 1'b0;
  logic [WORD-1:0]   mem_rdata = '0;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  always #5 clk = ~clk;

  dm_cache_fill #(
    .WORD     (WORD),
    .ADDR_W   (ADDR_W),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .busy       (busy),
    .inv        (inv),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Backing memory contents: block 0x0004 holds 0xA0..0xA3, elsewhere an address hash.
  function automatic logic [31:0] memWord(input logic [14:0] a);
    if (a[14:2] == 13'd1) return 32'hA0 + {30'd0, a[1:0]};
    return {a, 2'b10, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] expCnt(input int n);
    if (!STATS_EN) return 32'd0;
    return (n > 7) ? 32'd7 : n;
  endfunction

  // Reference model: per-line valid/tag; data is always the backing memory word.
  bit         mValid [1024];
  logic [2:0] mTag   [1024];
  int         mHits;
  int         mMisses;

  function automatic void modelClearValid();
    for (int i = 0; i < 1024; i++) mValid[i] = 1'b0;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0; inv = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    modelClearValid();
    mHits = 0;
    mMisses = 0;
  endtask

  // One read transaction with a memory responder; junk=1 adds gaps and ignored noise.
  task automatic doRead(input logic [14:0] addr, input bit junk, output bit gotReady,
                        output logic [31:0] data, output int lat, output int reqs,
                        output logic [14:0] fillAddr);
    int sent;
    bit filling;
    logic [14:0] wa;
    gotReady = 1'b0; data = '0; lat = 0; reqs = 0; fillAddr = '0; sent = 0; filling = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = addr;
    for (int cyc = 1; cyc <= 200 && !gotReady; cyc++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (mem_req) begin
        reqs++;
        fillAddr = mem_addr;
        filling = 1'b1;
      end
      if (filling) chk("mem_addr_stable", mem_addr, fillAddr);
      chk("busy_during", busy, 1);
      if (cpu_ready) begin
        gotReady = 1'b1;
        data = cpu_rdata;
        lat = cyc + 1;
        cpu_req = 1'b0;
      end else begin
        chk("rdata_zero_idle", cpu_rdata, 0);
        if (junk) begin
          cpu_req = 1'($urandom_range(0, 1));
          cpu_addr = 15'($urandom);
        end else begin
          cpu_req = 1'b0;
        end
        if (filling && sent < 4) begin
          if (!junk || $urandom_range(0, 2) != 0) begin
            wa = fillAddr + 15'(sent);
            mem_rvalid = 1'b1;
            mem_rdata = memWord(wa);
            sent++;
          end
        end else if (junk) begin
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end
      end
    end
    if (!gotReady) chk("ready_timeout", 0, 1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    cpu_req = 1'b0;
    chk("busy_after", busy, 0);
    chk("ready_after", cpu_ready, 0);
  endtask

  task automatic doInv(input bit withReq, input logic [14:0] addr);
    @(negedge clk);
    inv = 1'b1;
    cpu_req = withReq;
    cpu_addr = addr;
    @(negedge clk);
    inv = 1'b0;
    cpu_req = 1'b0;
    chk("inv_no_lookup", busy, 0);
    @(negedge clk);
    chk("inv_idle", busy, 0);
    chk("inv_no_ready", cpu_ready, 0);
    modelClearValid();
  endtask

  typedef struct {
    int          op;       // 0 read, 1 inv, 2 inv with simultaneous request
    logic [14:0] addr;
    bit          expHit;
    logic [31:0] expData;
    logic [14:0] expFill;
    int          expHc;
    int          expMc;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit gotReady;
    logic [31:0] data;
    int lat;
    int reqs;
    logic [14:0] fillAddr;
    bool_dummy: begin end

    tbl[0] = '{0, 15'h0005, 1'b0, 32'hA1, 15'h0004, 0, 1};
    tbl[1] = '{0, 15'h0006, 1'b1, 32'hA2, 15'h0000, 1, 1};
    tbl[2] = '{0, 15'h1004, 1'b0, memWord(15'h1004), 15'h1004, 1, 2};
    tbl[3] = '{0, 15'h0004, 1'b0, 32'hA0, 15'h0004, 1, 3};
    tbl[4] = '{0, 15'h0007, 1'b1, 32'hA3, 15'h0000, 2, 3};
    tbl[5] = '{1, 15'h0000, 1'b0, 32'h0,  15'h0000, 2, 3};
    tbl[6] = '{0, 15'h0006, 1'b0, 32'hA2, 15'h0004, 2, 4};
    tbl[7] = '{2, 15'h0006, 1'b0, 32'h0,  15'h0000, 2, 4};
    tbl[8] = '{0, 15'h0006, 1'b0, 32'hA2, 15'h0004, 2, 5};
    tbl[9] = '{0, 15'h0005, 1'b1, 32'hA1, 15'h0000, 3, 5};

    // Reset state straight after power-up.
    @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_mem_req", mem_req, 0);
    chk("init_mem_addr", mem_addr, 0);
    chk("init_cpu_ready", cpu_ready, 0);
    chk("init_cpu_rdata", cpu_rdata, 0);
    chk("init_hit_cnt", hit_cnt, 0);
    chk("init_miss_cnt", miss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    for (int v = 0; v < 10; v++) begin
      if (tbl[v].op == 0) begin
        doRead(tbl[v].addr, 1'b0, gotReady, data, lat, reqs, fillAddr);
        $display("vec %0d read addr=0x%04h data=0x%08h lat=%0d mem_reqs=%0d", v, tbl[v].addr, data, lat, reqs);
        chk("vec_ready", gotReady, 1);
        chk("vec_data", data, tbl[v].expData);
        if (tbl[v].expHit) begin
          chk("vec_hit_no_mem_req", reqs, 0);
          chk("vec_hit_latency", lat, 2);
        end else begin
          chk("vec_miss_mem_req_once", reqs, 1);
          chk("vec_miss_mem_addr", fillAddr, tbl[v].expFill);
        end
      end else begin
        doInv(tbl[v].op == 2, tbl[v].addr);
        $display("vec %0d invalidate with_req=%0d", v, tbl[v].op == 2);
      end
      chk("vec_hit_cnt", hit_cnt, expCnt(tbl[v].expHc));
      chk("vec_miss_cnt", miss_cnt, expCnt(tbl[v].expMc));
    end

    // Reset in the middle of a fill: after two of four words.
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 15'h0208;
    @(negedge clk);
    cpu_req = 1'b0;
    begin
      int waitCyc;
      waitCyc = 0;
      while (!mem_req && waitCyc < 20) begin
        @(negedge clk);
        waitCyc++;
      end
      chk("midfill_mem_req_seen", mem_req, 1);
    end
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = memWord(15'h0208 + 15'(k));
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    chk("midfill_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midfill_rst_busy", busy, 0);
    chk("midfill_rst_mem_req", mem_req, 0);
    chk("midfill_rst_miss_cnt", miss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    doRead(15'h0208, 1'b0, gotReady, data, lat, reqs, fillAddr);
    $display("midfill reread addr=0x0208 data=0x%08h mem_reqs=%0d", data, reqs);
    chk("midfill_reread_miss", reqs, 1);
    chk("midfill_reread_data", data, memWord(15'h0208));
    chk("midfill_reread_miss_cnt", miss_cnt, expCnt(1));

    // Counter saturation: one miss then nine hits on the same block.
    applyReset();
    doRead(15'h0005, 1'b0, gotReady, data, lat, reqs, fillAddr);
    chk("sat_first_miss", reqs, 1);
    for (int k = 0; k < 9; k++) begin
      doRead(15'h0004 + 15'(k % 4), 1'b0, gotReady, data, lat, reqs, fillAddr);
      $display("sat hit %0d data=0x%08h hit_cnt=%0d", k, data, hit_cnt);
      chk("sat_hit_no_mem_req", reqs, 0);
    end
    chk("sat_hit_cnt", hit_cnt, expCnt(9));
    chk("sat_miss_cnt", miss_cnt, expCnt(1));

    // Randomized reads over a small address pool to mix hits, misses and conflicts.
    applyReset();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        doInv(1'($urandom_range(0, 1)), 15'($urandom));
        $display("rand %0d invalidate", n);
      end else begin
        logic [2:0] t;
        logic [9:0] ix;
        logic [1:0] o;
        logic [14:0] a;
        bit expHit;
        t = 3'($urandom_range(0, 3));
        ix = 10'($urandom_range(0, 3));
        o = 2'($urandom_range(0, 3));
        a = {t, ix, o};
        expHit = mValid[ix] && (mTag[ix] == t);
        doRead(a, 1'b1, gotReady, data, lat, reqs, fillAddr);
        $display("rand %0d read addr=0x%04h data=0x%08h hit_exp=%0d mem_reqs=%0d", n, a, data, expHit, reqs);
        chk("rand_ready", gotReady, 1);
        chk("rand_data", data, memWord(a));
        if (expHit) begin
          chk("rand_hit_no_mem_req", reqs, 0);
          chk("rand_hit_latency", lat, 2);
          mHits++;
        end else begin
          chk("rand_miss_mem_req_once", reqs, 1);
          chk("rand_miss_mem_addr", fillAddr, {t, ix, 2'b00});
          mMisses++;
          mValid[ix] = 1'b1;
          mTag[ix] = t;
        end
        chk("rand_hit_cnt", hit_cnt, expCnt(mHits));
        chk("rand_miss_cnt", miss_cnt, expCnt(mMisses));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_cache_fill.md
DM_CACHE_FILL -- requirements
Module: dm_cache_fill

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 15, meaning the cpu word-address width.
REQ-003 SHALL have parameter INDEX_W, default 10, meaning log2 of the line count.
REQ-004 SHALL have parameter OFFSET_W, default 2, meaning log2 of the words per block; TAG_W = ADDR_W-INDEX_W-OFFSET_W, which must be at least 1.
REQ-005 SHALL have parameter CNT_W, default 15, meaning the statistics counter width.
REQ-006 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-007 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- cpu_req  in  1  read request
- cpu_addr  in  ADDR_W  word address
- cpu_rdata  out  WORD  read data
- cpu_ready  out  1  one-cycle response strobe
- busy  out  1  high when not IDLE
- inv  in  1  invalidate-all pulse
- mem_req  out  1  block fetch request
- mem_addr  out  ADDR_W  block-aligned fetch address
- mem_rvalid  in  1  fill word strobe
- mem_rdata  in  WORD  fill word
- hit_cnt  out  CNT_W  hit count
- miss_cnt  out  CNT_W  miss count

Function
REQ-008 SHALL implement a direct-mapped, read-only cache of 2^INDEX_W lines of 2^OFFSET_W words each, with a per-line tag and a flop-vector valid bit.
REQ-009 SHALL use FSM states IDLE, LOOKUP, FILL and RESP, with IDLE after reset.
REQ-010 SHALL behave in IDLE as follows:
- inv=1 clears all valid bits in one cycle and stays in IDLE.
- Otherwise cpu_req=1 captures cpu_addr and moves to LOOKUP.
- inv has priority over cpu_req; the request is dropped.
REQ-011 SHALL behave in LOOKUP as follows:
- Hit = valid[index] && tag match.
- On a hit, drive cpu_ready=1 and cpu_rdata = the addressed word in that cycle, then go to IDLE; a hit therefore has 2-cycle request-to-ready latency.
- On a miss, go to FILL.
REQ-012 SHALL, in FILL, pulse mem_req=1 for exactly the first FILL cycle, with mem_addr = {tag,index,OFFSET_W zeros}, held stable throughout FILL.
REQ-013 SHALL, in FILL, write each mem_rvalid word to offset 0,1,...,2^OFFSET_W-1 in order via a word counter; gaps between strobes are allowed.
REQ-014 SHALL, on the last fill word, write the tag, set valid[index] and go to RESP.
REQ-015 SHALL, in RESP, drive cpu_ready=1 with the requested word for one cycle, then go to IDLE.
REQ-016 SHALL ignore mem_rvalid outside FILL, inv outside IDLE, and cpu_addr/cpu_req changes while busy.
REQ-017 SHALL hold cpu_rdata at zero when cpu_ready=0.
REQ-018 SHALL increment hit_cnt on each LOOKUP hit and miss_cnt on each LOOKUP miss, with both counters saturating at all-ones.

Reset
REQ-019 SHALL, on rst, immediately set the FSM to IDLE, clear all valid bits, and set cpu_ready, mem_req, busy and both counters to 0, with mem_addr and the word counter at 0.
REQ-020 SHALL abort any fill in progress on rst and leave the partially filled line invalid; data and tag arrays are not reset.

Configuration
REQ-021 SHALL, with macro DM_CACHE_STATS_EN defined, implement hit_cnt/miss_cnt per REQ-018.
REQ-022 SHALL, without DM_CACHE_STATS_EN, keep the hit_cnt/miss_cnt ports but tie them to 0 with no counter flops.

Structure
REQ-023 SHALL place the FSM state enum, the default parameter values and the TAG_W derivation in shared package cache_pkg.
REQ-024 SHALL instantiate the data store as sub-module cache_data_ram: 1 write port and 1 read port, 2^(INDEX_W+OFFSET_W) x WORD, combinational read.

Verification
REQ-025 SHALL cover a cold miss: reset, then cpu_req addr 0x0005 -> mem_req once with mem_addr 0x0004; after 4 rvalids of 0xA0..0xA3, cpu_ready with 0xA1, and miss_cnt=1.
REQ-026 SHALL cover a hit after fill: read 0x0006 -> cpu_ready 2 cycles after request with 0xA2, no mem_req, and hit_cnt=1.
REQ-027 SHALL cover a tag conflict: read 0x1004 (same index, different tag) -> refill; a subsequent read of 0x0004 misses again.
REQ-028 SHALL cover invalidate: inv in IDLE, then read 0x0006 -> miss with a fresh mem_req; inv asserted together with cpu_req -> no LOOKUP.
REQ-029 SHALL cover reset mid-fill: rst after 2 of 4 rvalids -> busy=0 and mem_req=0 immediately, and a later read of the same address misses.
REQ-030 SHALL cover counter saturation (CNT_W=3): 9 hits -> hit_cnt=7; and with DM_CACHE_STATS_EN undefined, both counts stay 0.
